// File: rtl/ahb_write_capture.sv
// rtl/ahb_write_capture.sv - AHB-Lite write-only slave that pushes {hsize, haddr, hwdata} commands into a FIFO
module ahb_write_capture #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int CMD_W  = 3 + ADDR_W + DATA_W
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              wfull,
  output logic              hreadyout,
  output logic              hresp,
  output logic              winc,
  output logic [CMD_W-1:0]  wdata,
  output logic [7:0]        err_cnt
);

  localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_ERR1  = 2'd2,
    S_ERR2  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_haddr;
  logic [2:0]        r_hsize;
  logic [7:0]        r_err_cnt;

  logic              w_addr_valid;
  logic              w_size_ok;
  logic [2:0]        w_align_mask;
  logic              w_misalign;
  logic              w_write_ok;
  logic              w_sample;
  logic              w_unused;

  // htrans[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are handled alike
  assign w_unused     = htrans[0];
  assign w_addr_valid = hsel & hready & htrans[1];
  assign w_size_ok    = (hsize <= MAX_SIZE);

  always_comb begin
    w_align_mask = 3'b111;
    case (hsize)
      3'd0:    w_align_mask = 3'b000;
      3'd1:    w_align_mask = 3'b001;
      3'd2:    w_align_mask = 3'b011;
      default: w_align_mask = 3'b111;
    endcase
  end

  assign w_misalign = |(haddr[2:0] & w_align_mask);
  assign w_write_ok = hwrite & w_size_ok & ~w_misalign;

  always_comb begin
    w_state_next = r_state;
    w_sample     = 1'b0;
    hreadyout    = 1'b1;
    hresp        = 1'b0;
    winc         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sample = 1'b1;
      end
      S_WDATA: begin
        if (wfull) begin
          hreadyout = 1'b0;
        end else begin
          winc         = 1'b1;
          w_sample     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_ERR1: begin
        hreadyout    = 1'b0;
        hresp        = 1'b1;
        w_state_next = S_ERR2;
      end
      S_ERR2: begin
        hresp        = 1'b1;
        w_sample     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // The completing data phase doubles as the next address phase
    if (w_sample && w_addr_valid) begin
      w_state_next = w_write_ok ? S_WDATA : S_ERR1;
    end
    if (wrst) begin
      hreadyout = 1'b1;
      hresp     = 1'b0;
      winc      = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state   <= S_IDLE;
      r_haddr   <= '0;
      r_hsize   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_sample && w_addr_valid && w_write_ok) begin
        r_haddr <= haddr;
        r_hsize <= hsize;
      end
      if (w_state_next == S_ERR1 && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign err_cnt = r_err_cnt;
  assign wdata   = {r_hsize, r_haddr, hwdata};

endmodule

// File: tb/tb_ahb_write_capture.sv
// tb/tb_ahb_write_capture.sv - scoreboard bench for ahb_write_capture
module tb_ahb_write_capture;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 3 + ADDR_W + DATA_W;

  logic              wclk = 1'b0;
  logic              wrst;
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  wire               hready;
  logic              wfull;
  logic              hreadyout;
  logic              hresp;
  logic              winc;
  logic [CMD_W-1:0]  wdata;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CMD_W-1:0] exp_q[$];

  assign hready = hreadyout;

  always #5 wclk = ~wclk;

  ahb_write_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .wclk(wclk), .wrst(wrst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .wfull(wfull), .hreadyout(hreadyout), .hresp(hresp), .winc(winc),
    .wdata(wdata), .err_cnt(err_cnt)
  );

  // Monitor: every push is matched against the next expected command
  always @(negedge wclk) begin
    if (winc) begin
      n_checks++;
      if (wfull) begin
        n_fail++;
        $display("FAIL winc_while_full: winc=1 wfull=1 required winc=0");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_winc: wdata=%h with no expected push", wdata);
      end else begin
        logic [CMD_W-1:0] e;
        e = exp_q.pop_front();
        if (wdata !== e) begin
          n_fail++;
          $display("FAIL wdata: got %h expected %h", wdata, e);
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
  endtask

  task automatic addr_ph(input logic w, input logic [2:0] sz, input logic [31:0] a,
                         input logic [1:0] tr);
    hsel = 1'b1; htrans = tr; hwrite = w; hsize = sz; haddr = a;
  endtask

  task automatic do_reset();
    wrst = 1'b1; idle_bus(); wfull = 1'b0; hwdata = '0;
    step(); step();
    wrst = 1'b0;
  endtask

  task automatic err_xfer(input logic w, input logic [2:0] sz, input logic [31:0] a);
    addr_ph(w, sz, a, 2'd2);
    step();
    idle_bus();
    @(negedge wclk);
    chk1("err1_hreadyout", hreadyout, 1'b0);
    chk1("err1_hresp", hresp, 1'b1);
    step();
    @(negedge wclk);
    chk1("err2_hreadyout", hreadyout, 1'b1);
    chk1("err2_hresp", hresp, 1'b1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge wclk);
    chk1("rst_hreadyout", hreadyout, 1'b1);
    chk1("rst_hresp", hresp, 1'b0);
    chk1("rst_winc", winc, 1'b0);
    chk8("rst_err_cnt", err_cnt, 8'd0);
    step();

    // Single write
    addr_ph(1'b1, 3'd2, 32'h100, 2'd2);
    step();
    idle_bus();
    hwdata = 32'hDEADBEEF;
    exp_q.push_back({3'd2, 32'h100, 32'hDEADBEEF});
    @(negedge wclk);
    chk1("single_winc", winc, 1'b1);
    chk1("single_hreadyout", hreadyout, 1'b1);
    chk1("single_hresp", hresp, 1'b0);
    step();

    // Legal halfword at 0x102 then byte at 0x103, back to back
    addr_ph(1'b1, 3'd1, 32'h102, 2'd2);
    step();
    addr_ph(1'b1, 3'd0, 32'h103, 2'd2);
    hwdata = 32'h0000CAFE;
    exp_q.push_back({3'd1, 32'h102, 32'h0000CAFE});
    @(negedge wclk);
    chk1("half_winc", winc, 1'b1);
    step();
    idle_bus();
    hwdata = 32'h000000A5;
    exp_q.push_back({3'd0, 32'h103, 32'h000000A5});
    @(negedge wclk);
    chk1("byte_winc", winc, 1'b1);
    step();

    // Stall for three cycles on a full FIFO
    addr_ph(1'b1, 3'd2, 32'h300, 2'd2);
    step();
    idle_bus();
    hwdata = 32'h11223344;
    wfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      chk1("stall_hreadyout", hreadyout, 1'b0);
      chk1("stall_winc", winc, 1'b0);
      step();
    end
    wfull = 1'b0;
    exp_q.push_back({3'd2, 32'h300, 32'h11223344});
    @(negedge wclk);
    chk1("unstall_hreadyout", hreadyout, 1'b1);
    chk1("unstall_winc", winc, 1'b1);
    step();
    @(negedge wclk);
    chk1("unstall_single_push", winc, 1'b0);
    step();

    // Four back-to-back word writes
    for (int i = 0; i < 4; i++) begin
      addr_ph(1'b1, 3'd2, 32'(i * 4), (i == 0) ? 2'd2 : 2'd3);
      if (i > 0) begin
        hwdata = 32'hA0000000 + 32'(i - 1);
        exp_q.push_back({3'd2, 32'((i - 1) * 4), 32'hA0000000 + 32'(i - 1)});
        @(negedge wclk);
        chk1("b2b_winc", winc, 1'b1);
      end
      step();
    end
    idle_bus();
    hwdata = 32'hA0000003;
    exp_q.push_back({3'd2, 32'h0000000C, 32'hA0000003});
    @(negedge wclk);
    chk1("b2b_winc_last", winc, 1'b1);
    step();

    // Unselected and BUSY transfers are ignored
    addr_ph(1'b1, 3'd2, 32'h500, 2'd2);
    hsel = 1'b0;
    step();
    addr_ph(1'b1, 3'd2, 32'h504, 2'd1);
    @(negedge wclk);
    chk1("nosel_hreadyout", hreadyout, 1'b1);
    chk1("nosel_winc", winc, 1'b0);
    step();
    idle_bus();
    @(negedge wclk);
    chk1("busy_hreadyout", hreadyout, 1'b1);
    chk1("busy_winc", winc, 1'b0);
    step();

    // Reset in the middle of a stall discards the write
    addr_ph(1'b1, 3'd2, 32'h200, 2'd2);
    step();
    idle_bus();
    hwdata = 32'h00000055;
    wfull = 1'b1;
    @(negedge wclk);
    chk1("rststall_hreadyout", hreadyout, 1'b0);
    step();
    wrst = 1'b1;
    step();
    wrst = 1'b0;
    wfull = 1'b0;
    @(negedge wclk);
    chk1("rststall_after_hreadyout", hreadyout, 1'b1);
    chk1("rststall_after_winc", winc, 1'b0);
    chk1("rststall_after_hresp", hresp, 1'b0);
    step();
    @(negedge wclk);
    chk1("rststall_no_late_winc", winc, 1'b0);
    step();

    // Error responses
    do_reset();
    err_xfer(1'b0, 3'd2, 32'h20);
    err_xfer(1'b1, 3'd2, 32'h102);
    err_xfer(1'b1, 3'd3, 32'h100);
    @(negedge wclk);
    chk8("err_cnt_three", err_cnt, 8'd3);
    chk1("err_done_hresp", hresp, 1'b0);
    step();

    // A write issued during ERR2 is accepted
    addr_ph(1'b0, 3'd2, 32'h24, 2'd2);
    step();
    idle_bus();
    step();
    addr_ph(1'b1, 3'd2, 32'h40, 2'd2);
    @(negedge wclk);
    chk1("err2_sample_hresp", hresp, 1'b1);
    chk1("err2_sample_hreadyout", hreadyout, 1'b1);
    step();
    idle_bus();
    hwdata = 32'h00004040;
    exp_q.push_back({3'd2, 32'h40, 32'h00004040});
    @(negedge wclk);
    chk1("after_err2_winc", winc, 1'b1);
    chk1("after_err2_hresp", hresp, 1'b0);
    chk8("err_cnt_four", err_cnt, 8'd4);
    step();

    // Saturation
    do_reset();
    for (int i = 0; i < 260; i++) begin
      err_xfer(1'b0, 3'd0, 32'(i * 4));
      if (i == 254) chk8("err_cnt_255", err_cnt, 8'd255);
    end
    chk8("err_cnt_sat", err_cnt, 8'd255);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_pushes: got %0d outstanding expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_write_capture.md
AHB_WRITE_CAPTURE -- requirements
Module: ahb_write_capture

Interface
REQ-001 Parameter ADDR_W, default 32, AHB address width.
REQ-002 Parameter DATA_W, default 32, AHB data width; legal values are 32 and 64.
REQ-003 Parameter CMD_W, default 3+ADDR_W+DATA_W, FIFO command width; it is derived, never overridden.
REQ-004 wclk  in  1  sole clock; all state changes on its rising edge.
REQ-005 wrst  in  1  reset, synchronous, active-high.
REQ-006 hsel  in  1  slave select.
REQ-007 haddr  in  ADDR_W  address-phase address.
REQ-008 htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 hwrite  in  1  1=write, 0=read.
REQ-010 hsize  in  3  transfer size, log2 of bytes.
REQ-011 hwdata  in  DATA_W  data-phase write data.
REQ-012 hready  in  1  bus-level ready (previous transfer complete).
REQ-013 wfull  in  1  full flag from the FIFO write-side stage, registered, same clock.
REQ-014 hreadyout  out  1  slave ready.
REQ-015 hresp  out  1  0=OKAY, 1=ERROR.
REQ-016 winc  out  1  FIFO push strobe, one cycle per accepted write.
REQ-017 wdata  out  CMD_W  command word {hsize, haddr, hwdata}, valid only while winc=1.
REQ-018 err_cnt  out  8  count of ERROR responses, saturating.

Function
REQ-019 The block SHALL implement FSM states IDLE, WDATA, ERR1 and ERR2.
REQ-020 An address phase is valid when hsel & hready & htrans[1]; IDLE and BUSY transfers SHALL get a zero-wait OKAY response with no state change.
REQ-021 On a valid write address phase with legal size and alignment, the block SHALL register haddr and hsize and enter WDATA.
REQ-022 Legal size: hsize <= log2(DATA_W/8). Aligned: haddr[hsize-1:0]==0. Any violation, or hwrite=0, SHALL enter ERR1.
REQ-023 In WDATA with wfull=0: hreadyout=1, hresp=0, winc=1, and wdata={hsize_q, haddr_q, hwdata} in the same cycle; the push has zero added latency.
REQ-024 In WDATA with wfull=1: hreadyout=0, winc=0, and the state SHALL remain WDATA; the stall lasts until wfull=0, with no timeout.
REQ-025 A valid address phase sampled in the completing WDATA cycle SHALL be decoded per REQ-021/022, supporting back-to-back writes at 1 write/cycle.
REQ-026 ERR1: hreadyout=0, hresp=1, always followed by ERR2.
REQ-027 ERR2: hreadyout=1, hresp=1, and an address phase SHALL be sampled as in IDLE.
REQ-028 Reads are not supported; they SHALL always take the two-cycle ERROR response.
REQ-029 err_cnt SHALL increment by 1 on each ERR1 entry and hold at 255.
REQ-030 winc SHALL never be asserted in a cycle where wfull=1, and SHALL fire at most once per accepted address phase.
REQ-031 Outside WDATA/ERR1/ERR2: hreadyout=1, hresp=0, winc=0.
REQ-032 wdata SHALL be don't-care when winc=0; the bench checks it only when winc=1.

Reset
REQ-033 While wrst=1 at a wclk edge: state=IDLE, hreadyout=1, hresp=0, winc=0, err_cnt=0, and haddr_q/hsize_q cleared.
REQ-034 Reset asserted during a WDATA stall SHALL discard the pending write; no winc SHALL follow reset release.
REQ-035 Reset asserted during ERR1 SHALL abandon the error; err_cnt already incremented SHALL still clear.

Verification
REQ-036 Single write: NONSEQ, haddr=0x100, hsize=2, hwdata=0xDEADBEEF, wfull=0 -> next cycle winc=1, wdata={3'd2,0x100,0xDEADBEEF}, hreadyout=1.
REQ-037 Stall: write issued with wfull=1 held 3 cycles -> hreadyout=0 for 3 cycles with winc=0; on the cycle wfull=0, exactly one winc and hreadyout=1.
REQ-038 Back-to-back: 4 SEQ writes to 0x0/0x4/0x8/0xC, wfull=0 -> winc high 4 consecutive cycles with matching addresses in order.
REQ-039 Errors: read at 0x20; write hsize=2 at 0x102; write hsize=3 with DATA_W=32 -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), no winc, err_cnt=3.
REQ-040 Saturation: 260 error transfers -> err_cnt=255.
REQ-041 Reset mid-stall: write with wfull=1, then wrst pulsed for 1 cycle, then wfull=0 -> no winc, hreadyout=1, state IDLE.
